// File: rtl/controller_floatingpoint_mul_pkg.sv
// Shared constants for the floating-point multiply sequencer.
// State encodings and MULT counter sizing.
package fp_mul_ctrl_pkg;

  localparam int MCNT_W  = 4;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_MULT   = 3'd2;
  localparam state_t S_ROUND  = 3'd3;
  localparam state_t S_RENORM = 3'd4;
  localparam state_t S_OUTPUT = 3'd5;
  localparam state_t S_DONE   = 3'd6;

endpackage

// File: rtl/controller_floatingpoint_mul_if.sv
// Host handshake plus datapath control/status bundle.
// master = controller, slave = host/datapath side.
interface controller_floatingpoint_mul_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic             MLB_significand_mult;
  logic             MLB_exp_inc;
  logic             overflow_flag;
  logic             mux_en_reg;
  logic             enable_reg;
  logic             inc_shift_en;
  logic             mux_en_rounding;
  logic             enable_rounding;
  logic             busy;
  logic             done;
  logic             overflow_o;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  start,
    input  MLB_significand_mult,
    input  MLB_exp_inc,
    input  overflow_flag,
    output mux_en_reg,
    output enable_reg,
    output inc_shift_en,
    output mux_en_rounding,
    output enable_rounding,
    output busy,
    output done,
    output overflow_o,
    output op_count
  );

  modport slave (
    output start,
    output MLB_significand_mult,
    output MLB_exp_inc,
    output overflow_flag,
    input  mux_en_reg,
    input  enable_reg,
    input  inc_shift_en,
    input  mux_en_rounding,
    input  enable_rounding,
    input  busy,
    input  done,
    input  overflow_o,
    input  op_count
  );

endinterface

// File: rtl/controller_floatingpoint_mul.sv
// Sequencing FSM for the floating-point multiply datapath.
// Moore-decoded enables; only inc_shift_en in MULT sees status.
module controller_floatingpoint_mul
  import fp_mul_ctrl_pkg::*;
#(
  parameter int MULT_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic reset,
  controller_floatingpoint_mul_if.master bus
);

  if ((MULT_LATENCY < LAT_MIN) ||
      (MULT_LATENCY > LAT_MAX)) begin : g_bad_lat
    $error("MULT_LATENCY out of range 1..15");
  end

  localparam logic [MCNT_W-1:0] LAT_M1 =
    MCNT_W'(MULT_LATENCY - 1);

  state_t             state;
  state_t             state_nx;
  logic [MCNT_W-1:0]  mcnt;
  logic               renorm;
  logic               ovf_q;
  logic [CNT_W-1:0]   count;

  logic is_load;
  logic is_mult;
  logic is_round;
  logic is_renorm;
  logic is_output;
  logic is_done;
  logic mult_last;

  assign is_load   = (state == S_LOAD);
  assign is_mult   = (state == S_MULT);
  assign is_round  = (state == S_ROUND);
  assign is_renorm = (state == S_RENORM);
  assign is_output = (state == S_OUTPUT);
  assign is_done   = (state == S_DONE);
  assign mult_last = is_mult && (mcnt == '0);

  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:   state_nx = bus.start ? S_LOAD : S_IDLE;
      S_LOAD:   state_nx = S_MULT;
      S_MULT:   state_nx = mult_last ? S_ROUND : S_MULT;
      S_ROUND:
        state_nx = (bus.MLB_exp_inc && !renorm) ?
                   S_RENORM : S_OUTPUT;
      S_RENORM: state_nx = S_OUTPUT;
      S_OUTPUT: state_nx = S_DONE;
      S_DONE:   state_nx = bus.start ? S_LOAD : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      mcnt   <= '0;
      renorm <= 1'b0;
      ovf_q  <= 1'b0;
      count  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_LOAD: begin
          mcnt   <= LAT_M1;
          renorm <= 1'b0;
        end
        S_MULT:
          if (mcnt != '0) mcnt <= mcnt - 1'b1;
        S_ROUND:
          if (bus.MLB_exp_inc) renorm <= 1'b1;
        S_OUTPUT: ovf_q <= bus.overflow_flag;
        S_DONE:
          if (count != '1) count <= count + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.mux_en_reg      = is_mult;
  assign bus.enable_reg      = is_load | is_mult | is_output;
  assign bus.inc_shift_en    = is_renorm |
    (mult_last & bus.MLB_significand_mult);
  assign bus.mux_en_rounding = is_round;
  assign bus.enable_rounding = is_round | is_renorm;
  assign bus.busy            = (state != S_IDLE);
  assign bus.done            = is_done;
  assign bus.overflow_o      = ovf_q;
  assign bus.op_count        = count;

endmodule

// File: tb/tb_controller_floatingpoint_mul.sv
// Bench: two controller instances (latency 1 and 3) against
// a cycle-timeline model, plus directed literal checks.
module tb_controller_floatingpoint_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sig = 1'b0;
  logic expi = 1'b0;
  logic ovf = 1'b0;

  always #5 clk = ~clk;

  controller_floatingpoint_mul_if #(.CNT_W(16)) bus0 ();
  controller_floatingpoint_mul_if #(.CNT_W(3))  bus1 ();

  assign bus0.start = start;
  assign bus0.MLB_significand_mult = sig;
  assign bus0.MLB_exp_inc = expi;
  assign bus0.overflow_flag = ovf;
  assign bus1.start = start;
  assign bus1.MLB_significand_mult = sig;
  assign bus1.MLB_exp_inc = expi;
  assign bus1.overflow_flag = ovf;

  controller_floatingpoint_mul #(
    .MULT_LATENCY(1), .CNT_W(16)
  ) dut0 (.clk(clk), .reset(rst), .bus(bus0));

  controller_floatingpoint_mul #(
    .MULT_LATENCY(3), .CNT_W(3)
  ) dut1 (.clk(clk), .reset(rst), .bus(bus1));

  // {mux_en_reg, enable_reg, inc_shift_en, mux_en_rounding,
  //  enable_rounding, busy, done, overflow_o}
  logic [7:0] act_o [2];
  int         act_cnt [2];

  always_comb begin
    act_o[0] = {bus0.mux_en_reg, bus0.enable_reg,
                bus0.inc_shift_en, bus0.mux_en_rounding,
                bus0.enable_rounding, bus0.busy,
                bus0.done, bus0.overflow_o};
    act_o[1] = {bus1.mux_en_reg, bus1.enable_reg,
                bus1.inc_shift_en, bus1.mux_en_rounding,
                bus1.enable_rounding, bus1.busy,
                bus1.done, bus1.overflow_o};
    act_cnt[0] = int'(bus0.op_count);
    act_cnt[1] = int'(bus1.op_count);
  end

  int checks = 0;
  int errors = 0;

  int lat  [2] = '{1, 3};
  int cmax [2] = '{65535, 7};
  bit active [2];
  int t      [2];
  bit rn     [2];
  bit ovf_e  [2];
  int cnt_e  [2];

  // t = cycles since the op was accepted (1 = LOAD).
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        active[i] = 0; t[i] = 0; rn[i] = 0;
        ovf_e[i] = 0; cnt_e[i] = 0;
      end else if (!active[i]) begin
        if (start) begin
          active[i] = 1; t[i] = 1; rn[i] = 0;
        end
      end else begin
        if (t[i] == 2 + lat[i] && expi) rn[i] = 1;
        if (t[i] == 3 + lat[i] + int'(rn[i]))
          ovf_e[i] = ovf;
        if (t[i] == 4 + lat[i] + int'(rn[i])) begin
          if (cnt_e[i] < cmax[i]) cnt_e[i]++;
          if (start) begin
            t[i] = 1; rn[i] = 0;
          end else begin
            active[i] = 0; t[i] = 0;
          end
        end else begin
          t[i]++;
        end
      end
    end
  end

  function automatic logic [7:0] exp_vec(int i);
    int L = lat[i];
    int r = int'(rn[i]);
    int tt = t[i];
    bit a = active[i];
    bit ld = a && tt == 1;
    bit ml = a && tt >= 2 && tt <= 1 + L;
    bit rd = a && tt == 2 + L;
    bit re = a && rn[i] && tt == 3 + L;
    bit op = a && tt == 3 + L + r;
    bit dn = a && tt == 4 + L + r;
    bit inc = re || (a && tt == 1 + L && sig);
    return {ml, ld | ml | op, inc, rd, rd | re,
            a, dn, ovf_e[i]};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      e = exp_vec(i);
      checks++;
      if (act_o[i] !== e || act_cnt[i] != cnt_e[i]) begin
        errors++;
        $display("FAIL model[%0d] t=%0t: outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                 i, $time, act_o[i], act_cnt[i], e, cnt_e[i]);
      end
    end
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && (act_o[0][2] || act_o[1][2]); k++)
      step();
    chk("idle_wait", int'(act_o[0][2] | act_o[1][2]), 0);
  endtask

  task automatic run_op(input bit s_sig, input bit s_exp,
                        input bit s_ovf,
                        output int d0, output int d1,
                        output int i0, output int i1);
    wait_idle();
    sig = s_sig; expi = s_exp; ovf = s_ovf; start = 1;
    d0 = 0; d1 = 0; i0 = 0; i1 = 0;
    for (int c = 1; c <= 40 && (d0 == 0 || d1 == 0); c++) begin
      @(posedge clk);
      #2;
      start = 0;
      @(negedge clk);
      if (d0 == 0 && act_o[0][1]) d0 = c;
      if (d1 == 0 && act_o[1][1]) d1 = c;
      if (i0 == 0 && act_o[0][5]) i0 = c;
      if (i1 == 0 && act_o[1][5]) i1 = c;
    end
  endtask

  initial begin
    int d0, d1, i0, i1, gaps;
    #1 rst = 0;
    step();
    step();
    chk("rst_outs0", int'(act_o[0]), 0);
    chk("rst_outs1", int'(act_o[1]), 0);
    chk("rst_cnt0", act_cnt[0], 0);
    rst = 1;
    step();

    run_op(0, 0, 0, d0, d1, i0, i1);
    chk("t1_done0", d0, 5);
    chk("t1_done1", d1, 7);
    chk("t1_inc0", i0, 0);
    chk("t1_ovf0", int'(act_o[0][0]), 0);

    run_op(1, 0, 0, d0, d1, i0, i1);
    chk("t2_done0", d0, 5);
    chk("t2_inc0", i0, 2);
    chk("t2_inc1", i1, 4);

    run_op(0, 0, 1, d0, d1, i0, i1);
    chk("t3_ovf0", int'(act_o[0][0]), 1);
    chk("t3_ovf1", int'(act_o[1][0]), 1);
    run_op(0, 0, 0, d0, d1, i0, i1);
    chk("t3_clr0", int'(act_o[0][0]), 0);
    chk("t3_clr1", int'(act_o[1][0]), 0);

    run_op(0, 1, 0, d0, d1, i0, i1);
    chk("t4_done0", d0, 6);
    chk("t4_done1", d1, 8);
    chk("t4_inc0", i0, 4);
    chk("t4_inc1", i1, 6);
    chk("t4_cnt0", act_cnt[0], 5);

    sig = 0; expi = 0; ovf = 0; start = 1;
    gaps = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (!act_o[0][2]) gaps++;
    end
    start = 0;
    chk("t5_gaps0", gaps, 0);
    chk("t5_sat1", act_cnt[1], 7);

    wait_idle();
    start = 1;
    step();
    start = 0;
    step();
    rst = 0;
    #1;
    chk("t6_outs0", int'(act_o[0]), 0);
    chk("t6_outs1", int'(act_o[1]), 0);
    chk("t6_cnt0", act_cnt[0], 0);
    chk("t6_cnt1", act_cnt[1], 0);
    step();
    rst = 1;
    step();
    run_op(0, 0, 0, d0, d1, i0, i1);
    chk("t6_done0", d0, 5);
    chk("t6_cntpost0", act_cnt[0], 1);

    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(0, 2) == 0);
      sig = 1'($urandom_range(0, 1));
      expi = 1'($urandom_range(0, 1));
      ovf = 1'($urandom_range(0, 1));
      step();
    end
    start = 0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_floatingpoint_mul.md
Name: controller_floatingpoint_mul

Overview:
Sequencing FSM for datapath_floatingpoint_mul. It accepts a start request and drives the datapath's register, multiply-normalise, rounding and output-latch enables in the correct cycle order. It reacts to the datapath status bits (MLB_significand_mult, MLB_exp_inc, overflow_flag) and returns a done pulse with a latched overflow status to the requester. It sits between the top-level bus/host logic and the datapath; A/B operands go directly to the datapath.

Parameters:
MULT_LATENCY, 1, number of cycles the MULT state is held (1..15) for a pipelined significand multiplier.
CNT_W, 16, width of the saturating completed-operation counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request a multiply. Sampled only in IDLE or DONE.
MLB_significand_mult  in  1  datapath: product MSB set; normalise shift plus exponent increment required.
MLB_exp_inc  in  1  datapath: rounding carried out of the significand; renormalisation required.
overflow_flag  in  1  datapath: exponent overflow on the current result.
mux_en_reg  out  1  datapath: select product/exponent-sum into working registers (0 selects A/B).
enable_reg  out  1  datapath: working/output register load enable.
inc_shift_en  out  1  datapath: normalise shift plus exponent increment.
mux_en_rounding  out  1  datapath: select rounding adder path (0 selects renormalise path).
enable_rounding  out  1  datapath: rounding register enable.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse; result valid on datapath result.
overflow_o  out  1  overflow status of the last completed op.
op_count  out  CNT_W  completed operations, saturating.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, MULT counter=0, renorm flag=0, overflow_o=0, op_count=0. All control outputs, busy and done are 0.
- States (3-bit): IDLE, LOAD, MULT, ROUND, RENORM, OUTPUT, DONE.
- Outputs are Moore-decoded from the registered state. The only exception is inc_shift_en in MULT.
- IDLE: all controls 0. On start=1, go to LOAD.
- LOAD: enable_reg=1, mux_en_reg=0 (operands latched). Clear the renorm flag. Go to MULT and load the counter with MULT_LATENCY-1.
- MULT: enable_reg=1, mux_en_reg=1.
  - inc_shift_en = MLB_significand_mult, on the final MULT cycle only (counter==0). It is 0 on earlier cycles.
  - When the counter reaches 0, go to ROUND; otherwise decrement.
- ROUND: enable_rounding=1, mux_en_rounding=1.
  - If MLB_exp_inc=1 and the renorm flag is 0: go to RENORM and set the flag.
  - Otherwise go to OUTPUT.
- RENORM: enable_rounding=1, mux_en_rounding=0, inc_shift_en=1. Go to OUTPUT. At most one renorm per op.
- OUTPUT: enable_reg=1. Capture overflow_flag into overflow_o at the clock edge. Go to DONE.
- DONE: done=1. Increment op_count (saturating at all-ones).
  - If start=1, go to LOAD (back-to-back operation).
  - Otherwise go to IDLE.
- start is ignored in LOAD, MULT, ROUND, RENORM and OUTPUT. It is not queued.
- Latency: done is high in cycle 4+MULT_LATENCY+R after the edge that sampled start, where R=1 if a renorm occurred, else 0. With defaults and no renorm, done is high in cycle 5.
- overflow_o holds its value from OUTPUT until the next OUTPUT state.
- Reset asserted mid-operation aborts immediately to the reset state. Datapath contents are don't-care afterwards.
- An out-of-range MULT_LATENCY (0 or >15) is an elaboration error.
- Illegal state encodings go to IDLE.

Decomposition:
- Package fp_mul_ctrl_pkg holds:
  - the state enumeration (3-bit) and its encodings;
  - the MULT counter width (4) and the MULT_LATENCY bounds.
- No sub-module. Optional wrapper fp_mul_top instantiates the controller with datapath_floatingpoint_mul.

Test Plan:
1. A=0x3FC00000 (1.5), B=0x40000000 (2.0), controller + datapath, defaults. Pulse start → LOAD/MULT/ROUND/OUTPUT/DONE sequence, inc_shift_en=0, done in cycle 5, result=0x40400000, overflow_o=0, op_count=1.
2. A=B=0x3FC00000 (1.5×1.5). MLB_significand_mult=1 → inc_shift_en=1 in the MULT cycle, result=0x40100000, done in cycle 5.
3. A=B=0xF0400000. overflow_flag=1 at OUTPUT → overflow_o=1 with done, held until the next op. A following 1.5×2.0 clears it to 0.
4. Controller alone, status bits forced: MLB_exp_inc=1 in ROUND → one RENORM cycle (inc_shift_en=1, mux_en_rounding=0), done in cycle 6. MLB_exp_inc held high → still only one RENORM.
5. MULT_LATENCY=3, start held high continuously:
   - MULT lasts 3 cycles, with inc_shift_en only on the 3rd.
   - DONE→LOAD with no IDLE gap.
   - op_count increments once per done.
   - start during busy is ignored.
6. reset=0 asserted during MULT → all outputs 0 asynchronously. After release, state is IDLE, op_count=0, and a new start completes normally.
